// File: rtl/fpu_interco_pkg.sv
// Shared FPU interconnect widths and the unit response record.
// Width defaults here seed the parameters of the response-path blocks.
package fpu_interco_pkg;

    localparam int unsigned FPU_DATA_WIDTH    = 32;
    localparam int unsigned FPU_NB_ARGS       = 3;
    localparam int unsigned FPU_OPCODE_WIDTH  = 6;
    localparam int unsigned FPU_DSFLAGS_WIDTH = 15;
    localparam int unsigned FPU_USFLAGS_WIDTH = 5;

    // Packed layout {rdata, rflags}; the buffer stores responses in this order.
    typedef struct packed {
        logic [FPU_DATA_WIDTH-1:0]    rdata;
        logic [FPU_USFLAGS_WIDTH-1:0] rflags;
    } fpu_resp_t;

endpackage

// File: rtl/fpu_resp_fifo.sv
// Circular response store: head readable combinationally, push/pop take effect at the clock edge.
// A push while full is ignored unless a pop happens in the same cycle.
module fpu_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        // Pointer width equals log2(DEPTH), so the increment wraps for free.
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fpu_resp_buffer.sv
// Credit-limited request pass-through with an in-order response buffer and zero-latency bypass.
// Requests stall once DEPTH ops are outstanding; the unit cannot be stalled, so stray responses are dropped and flagged.
module fpu_resp_buffer
    import fpu_interco_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = FPU_DATA_WIDTH,
    parameter int unsigned NB_ARGS       = FPU_NB_ARGS,
    parameter int unsigned OPCODE_WIDTH  = FPU_OPCODE_WIDTH,
    parameter int unsigned DSFLAGS_WIDTH = FPU_DSFLAGS_WIDTH,
    parameter int unsigned USFLAGS_WIDTH = FPU_USFLAGS_WIDTH,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          slv_req_i,
    output logic                          slv_gnt_o,
    input  logic [NB_ARGS*DATA_WIDTH-1:0] slv_operands_i,
    input  logic [OPCODE_WIDTH-1:0]       slv_op_i,
    input  logic [DSFLAGS_WIDTH-1:0]      slv_flags_i,
    input  logic                          slv_rready_i,
    output logic                          slv_rvalid_o,
    output logic [DATA_WIDTH-1:0]         slv_rdata_o,
    output logic [USFLAGS_WIDTH-1:0]      slv_rflags_o,
    output logic                          mst_req_o,
    input  logic                          mst_gnt_i,
    output logic [NB_ARGS*DATA_WIDTH-1:0] mst_operands_o,
    output logic [OPCODE_WIDTH-1:0]       mst_op_o,
    output logic [DSFLAGS_WIDTH-1:0]      mst_flags_o,
    input  logic                          mst_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         mst_rdata_i,
    input  logic [USFLAGS_WIDTH-1:0]      mst_rflags_i,
    output logic [$clog2(DEPTH):0]        inflight_o,
    output logic                          err_o
);
    localparam int unsigned IW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = DATA_WIDTH + USFLAGS_WIDTH;

    logic [IW-1:0] inflight_q, inflight_d;
    logic          err_q, err_d;
    logic [IW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [RW-1:0] fifo_dout, resp_sel;
    logic          can_issue, granted, handshake, rsp_ok;

    assign mst_operands_o = slv_operands_i;
    assign mst_op_o       = slv_op_i;
    assign mst_flags_o    = slv_flags_i;

    assign can_issue = (inflight_q < IW'(DEPTH));
    assign mst_req_o = slv_req_i && can_issue;
    assign slv_gnt_o = mst_gnt_i && can_issue;
    assign granted   = mst_req_o && mst_gnt_i;

    // Every outstanding op already holding a buffered answer means this response has no owner.
    assign fifo_pop  = !fifo_empty && slv_rready_i;
    assign rsp_ok    = mst_rvalid_i && (inflight_q != fifo_cnt) && !(fifo_full && !fifo_pop);
    assign fifo_push = rsp_ok && (!fifo_empty || !slv_rready_i);

    always_comb begin
        slv_rvalid_o = fifo_empty ? rsp_ok : 1'b1;
        resp_sel     = fifo_empty ? {mst_rdata_i, mst_rflags_i} : fifo_dout;
        if (!slv_rvalid_o) resp_sel = '0;
        {slv_rdata_o, slv_rflags_o} = resp_sel;
    end

    assign handshake = slv_rvalid_o && slv_rready_i;

    always_comb begin
        inflight_d = inflight_q;
        if (granted && !handshake)      inflight_d = inflight_q + 1'b1;
        else if (!granted && handshake) inflight_d = inflight_q - 1'b1;
        err_d = err_q || (mst_rvalid_i && !rsp_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight_o = inflight_q;
    assign err_o      = err_q;

    fpu_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  ({mst_rdata_i, mst_rflags_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_fpu_resp_buffer.sv
// Bench for fpu_resp_buffer: cycle table for bypass/credit/buffering plus hand sequences for corner cases.
module tb_fpu_resp_buffer;
    import fpu_interco_pkg::*;

    logic        clk, rst_n;
    logic        slv_req_i, slv_gnt_o, slv_rready_i, slv_rvalid_o;
    logic [95:0] slv_operands_i, mst_operands_o;
    logic [5:0]  slv_op_i, mst_op_o;
    logic [14:0] slv_flags_i, mst_flags_o;
    logic [31:0] slv_rdata_o, mst_rdata_i;
    logic [4:0]  slv_rflags_o, mst_rflags_i;
    logic        mst_req_o, mst_gnt_i, mst_rvalid_i, err_o;
    logic [2:0]  inflight_o;

    fpu_resp_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .slv_req_i(slv_req_i), .slv_gnt_o(slv_gnt_o),
        .slv_operands_i(slv_operands_i), .slv_op_i(slv_op_i), .slv_flags_i(slv_flags_i),
        .slv_rready_i(slv_rready_i), .slv_rvalid_o(slv_rvalid_o),
        .slv_rdata_o(slv_rdata_o), .slv_rflags_o(slv_rflags_o),
        .mst_req_o(mst_req_o), .mst_gnt_i(mst_gnt_i),
        .mst_operands_o(mst_operands_o), .mst_op_o(mst_op_o), .mst_flags_o(mst_flags_o),
        .mst_rvalid_i(mst_rvalid_i), .mst_rdata_i(mst_rdata_i), .mst_rflags_i(mst_rflags_i),
        .inflight_o(inflight_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req, gnt, mv;
        logic [31:0] d;
        logic        rr;
        logic        e_mreq, e_gnt, e_rv;
        logic [31:0] e_rd;
        int          e_inf, e_cnt;
    } vec_t;

    vec_t      vec [17];
    fpu_resp_t sb [$];
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic sb_check();
        fpu_resp_t e;
        if (slv_rvalid_o && slv_rready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=%0h required=none", slv_rdata_o);
            end else begin
                e = sb.pop_front();
                chk("sb_order", {slv_rdata_o, slv_rflags_o}, e);
            end
        end
    endtask

    // Drive one cycle's inputs just after the edge, then sample 3 ns later.
    task automatic cyc(input logic req, input logic gnt, input logic mv, input logic [31:0] d,
                       input logic rr, input bit legit);
        fpu_resp_t r;
        slv_req_i    = req;
        mst_gnt_i    = gnt;
        mst_rvalid_i = mv;
        mst_rdata_i  = d;
        mst_rflags_i = d[4:0];
        slv_rready_i = rr;
        r.rdata  = d;
        r.rflags = d[4:0];
        if (mv && legit) sb.push_back(r);
        #3;
        sb_check();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            req gnt mv  d             rr  mreq gnt rv  e_rd          inf cnt
        vec[0]  = '{1, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 0};
        vec[1]  = '{0, 0, 1, 32'h3F800000, 1, 0, 0, 1, 32'h3F800000, 1, 0};
        vec[2]  = '{0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0, 0};
        vec[3]  = '{1, 1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0};
        vec[4]  = '{1, 1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        1, 0};
        vec[5]  = '{1, 1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        2, 0};
        vec[6]  = '{1, 1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        3, 0};
        vec[7]  = '{1, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        4, 0};
        vec[8]  = '{0, 0, 1, 32'hA,        0, 0, 0, 1, 32'hA,        4, 0};
        vec[9]  = '{0, 0, 1, 32'hB,        0, 0, 0, 1, 32'hA,        4, 1};
        vec[10] = '{0, 0, 1, 32'hC,        0, 0, 0, 1, 32'hA,        4, 2};
        vec[11] = '{0, 0, 1, 32'hD,        0, 0, 0, 1, 32'hA,        4, 3};
        vec[12] = '{0, 1, 0, 32'h0,        1, 0, 0, 1, 32'hA,        4, 4};
        vec[13] = '{0, 1, 0, 32'h0,        1, 0, 1, 1, 32'hB,        3, 3};
        vec[14] = '{0, 1, 0, 32'h0,        1, 0, 1, 1, 32'hC,        2, 2};
        vec[15] = '{0, 1, 0, 32'h0,        1, 0, 1, 1, 32'hD,        1, 1};
        vec[16] = '{0, 1, 0, 32'h0,        1, 0, 1, 0, 32'h0,        0, 0};

        rst_n = 1'b0;
        slv_req_i = 0; mst_gnt_i = 0; mst_rvalid_i = 0; mst_rdata_i = '0;
        mst_rflags_i = '0; slv_rready_i = 0;
        slv_operands_i = {$urandom, $urandom, $urandom};
        slv_op_i = 6'($urandom);
        slv_flags_i = 15'($urandom);
        #2;
        chk("rst_inflight", inflight_o, 0);
        chk("rst_rvalid", slv_rvalid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_gnt", slv_gnt_o, 0);
        chk("rst_mreq", mst_req_o, 0);
        next();
        next();
        rst_n = 1'b1;
        next();

        for (int i = 0; i < 17; i++) begin
            cyc(vec[i].req, vec[i].gnt, vec[i].mv, vec[i].d, vec[i].rr, 1'b1);
            chk($sformatf("v%0d_mreq", i), mst_req_o, vec[i].e_mreq);
            chk($sformatf("v%0d_gnt", i), slv_gnt_o, vec[i].e_gnt);
            chk($sformatf("v%0d_rvalid", i), slv_rvalid_o, vec[i].e_rv);
            chk($sformatf("v%0d_rdata", i), slv_rdata_o, vec[i].e_rd);
            chk($sformatf("v%0d_rflags", i), slv_rflags_o, vec[i].e_rv ? vec[i].e_rd[4:0] : 5'd0);
            chk($sformatf("v%0d_inflight", i), inflight_o, vec[i].e_inf);
            chk($sformatf("v%0d_cnt", i), dut.fifo_cnt, vec[i].e_cnt);
            if (i == 0) begin
                chk("pass_operands", mst_operands_o, slv_operands_i);
                chk("pass_op", mst_op_o, slv_op_i);
                chk("pass_flags", mst_flags_o, slv_flags_i);
            end
            next();
        end

        // Simultaneous push/pop and grant/handshake with two entries buffered.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, 1);
            next();
        end
        cyc(0, 0, 1, 32'h11, 0, 1); next();
        cyc(0, 0, 1, 32'h22, 0, 1); next();
        cyc(0, 0, 0, 0, 0, 1);
        chk("sim_cnt_pre", dut.fifo_cnt, 2);
        chk("sim_inf_pre", inflight_o, 3);
        next();
        cyc(1, 1, 1, 32'h33, 1, 1);
        next();
        cyc(0, 0, 0, 0, 0, 1);
        chk("sim_cnt_post", dut.fifo_cnt, 2);
        chk("sim_inf_post", inflight_o, 3);
        next();
        cyc(0, 0, 0, 0, 1, 1); next();
        cyc(0, 0, 0, 0, 1, 1); next();
        cyc(0, 0, 0, 0, 0, 1);
        chk("sim_inf_drain", inflight_o, 1);
        chk("sim_cnt_drain", dut.fifo_cnt, 0);
        next();
        cyc(0, 0, 1, 32'h44, 1, 1); next();
        cyc(0, 0, 0, 0, 0, 1);
        chk("sim_inf_zero", inflight_o, 0);
        next();

        // Unexpected response with nothing outstanding.
        cyc(0, 0, 1, 32'hDEAD, 1, 0);
        chk("err_pre", err_o, 0);
        chk("err_rvalid_same", slv_rvalid_o, 0);
        next();
        cyc(0, 0, 0, 0, 1, 0);
        chk("err_set", err_o, 1);
        chk("err_rvalid_after", slv_rvalid_o, 0);
        chk("err_cnt", dut.fifo_cnt, 0);
        next();
        next();
        chk("err_sticky", err_o, 1);

        // Reset with 3 ops outstanding and 2 responses buffered.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, 1);
            next();
        end
        cyc(0, 0, 1, 32'h55, 0, 1); next();
        cyc(0, 0, 1, 32'h66, 0, 1); next();
        cyc(0, 0, 0, 0, 0, 1);
        chk("mrst_inf_pre", inflight_o, 3);
        rst_n = 1'b0;
        #1;
        chk("mrst_inflight", inflight_o, 0);
        chk("mrst_rvalid", slv_rvalid_o, 0);
        chk("mrst_err", err_o, 0);
        chk("mrst_cnt", dut.fifo_cnt, 0);
        sb.delete();
        next();
        rst_n = 1'b1;
        next();
        cyc(0, 0, 1, 32'h77, 0, 0); next();
        cyc(0, 0, 0, 0, 0, 0);
        chk("post_rst_err", err_o, 1);
        chk("post_rst_cnt", dut.fifo_cnt, 0);
        next();

        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
